instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the program-memory read interface: generates `rom_addr`, consumes `rom_data` from the synchronous program ROM, and delivers instructions to the CPU decode stage.
- The ROM samples `rom_addr` on every rising `clk` and presents the word one cycle later, with no enable.
- This block owns the program counter, sequential fetch, jump redirect and a valid/ready output with a 1-entry skid buffer.
- Sustains one instruction per cycle with no bubbles while the consumer is ready.

Parameters:
- ADDR_W, 16, program address width (matches ROM `address`).
- DATA_W, 16, instruction width (matches ROM `data_out`).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rom_addr  output  ADDR_W  address to ROM; equals internal pc register.
- rom_data  input  DATA_W  ROM read data; word for the address sampled at the previous edge.
- halt  input  1  when high, no new fetches are issued; in-flight words still drain.
- jump_en  input  1  redirect request, sampled on clk.
- jump_addr  input  ADDR_W  redirect target.
- instr  output  DATA_W  registered instruction.
- instr_pc  output  ADDR_W  address of `instr`.
- instr_valid  output  1  `instr`/`instr_pc` valid.
- instr_ready  input  1  consumer accepts when `instr_valid` && `instr_ready` at the edge.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, so rom_addr=RESET_PC.
  - b_valid=0, s_valid=0.
  - instr_valid=0, instr=0, instr_pc=0.
- Pipeline:
  - A is pc / rom_addr.
  - B is rom_data tagged by b_pc, b_valid.
  - S is the skid entry (s_instr, s_pc, s_valid).
  - C is the output register.
- Latency: a word fetched at address X appears at C two edges after pc=X is presented.
- out_free = !instr_valid || instr_ready.
- C update when out_free:
  - if s_valid, load C from S and clear S;
  - else if b_valid, load C from {rom_data, b_pc};
  - else instr_valid<=0.
- C update when !out_free:
  - C holds.
  - If b_valid, capture {rom_data, b_pc} into S; S is guaranteed empty in this case.
- s_valid_next is the S occupancy after the update above.
- fetch_go = !halt && !s_valid_next.
  - If fetch_go: b_pc<=pc, b_valid<=1, pc<=pc+1.
  - Else: b_valid<=0 and pc holds; the same address is re-presented and refetched later.
- PC arithmetic is modulo 2^ADDR_W: pc=all-ones increments to 0, with no flag.
- Jump (jump_en=1 at an edge) has highest priority:
  - pc<=jump_addr, b_valid<=0, s_valid<=0, instr_valid<=0.
  - An unaccepted word in C is discarded.
  - The target word appears with instr_valid=1 two edges later.
  - Jump during halt: pc is loaded, but no fetch occurs until halt falls.
  - Jump in the same cycle as an accept: the accept completes (consumer took it), then the flush happens.
- halt does not flush; B/S/C drain normally. Deasserting halt resumes at the held pc with no skipped or duplicated address.
- Ordering guarantee: instr_pc values delivered between jumps are strictly consecutive (mod 2^ADDR_W); no word is dropped or duplicated under any instr_ready pattern.
- Reset mid-stream: all valids clear immediately (async); fetch restarts at RESET_PC after rst_n rises.

Test Plan:
- Reset release, instr_ready=1, ROM[i]=0x1000+i -> instr_valid first high 2 edges after release with instr_pc=0, instr=0x1000; then one word per cycle, pc 1, 2, 3…
- Stream running, instr_ready low for 3 cycles at instr_pc=4 ->
  - C holds 4 throughout;
  - S holds 5;
  - rom_addr freezes;
  - on ready high, sequence 4, 5, 6, 7 is delivered with no gaps or duplicates.
- jump_en with jump_addr=0x0100 while C holds an unaccepted word ->
  - instr_valid=0 next cycle;
  - the next delivered word has instr_pc=0x0100 two edges after the jump;
  - no stale words appear.
- Wrap: jump_addr=0xFFFE, ready=1 -> instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- halt asserted at pc=10 -> in-flight words drain and instr_valid falls; halt released -> delivery resumes at the next consecutive pc.
- Random instr_ready (50%) for 1000 cycles plus random jumps -> scoreboard confirms consecutive instr_pc between jumps and instr==ROM[instr_pc]; rst_n pulse mid-stream clears instr_valid asynchronously.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program counter, ROM fetch pipeline and valid/ready
// instruction output with a 1-entry skid buffer.
module instruction_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);
  logic [ADDR_W-1:0] pc, b_pc, s_pc;
  logic [DATA_W-1:0] s_instr;
  logic b_valid, s_valid, out_free, s_valid_next, fetch_go;

  assign rom_addr = pc;

  // Fetching stops whenever the skid entry will be occupied, so S and B are never both full.
  always_comb begin
    out_free = !instr_valid || instr_ready;
    s_valid_next = !out_free && (s_valid || b_valid);
    fetch_go = !halt && !s_valid_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      b_pc <= '0;
      b_valid <= 1'b0;
      s_pc <= '0;
      s_instr <= '0;
      s_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (jump_en) begin
      pc <= jump_addr;
      b_valid <= 1'b0;
      s_valid <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      if (out_free) begin
        instr_valid <= s_valid || b_valid;
        if (s_valid) begin
          instr <= s_instr;
          instr_pc <= s_pc;
        end else if (b_valid) begin
          instr <= rom_data;
          instr_pc <= b_pc;
        end
      end else if (b_valid) begin
        s_instr <= rom_data;
        s_pc <= b_pc;
      end
      s_valid <= s_valid_next;
      b_valid <= fetch_go;
      if (fetch_go) begin
        b_pc <= pc;
        pc <= pc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plus randomized stream checked against a
// delivery-order model of the fetch unit.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_addr, rom_data = '0;
  logic        halt = 1'b0, jump_en = 1'b0, instr_ready = 1'b1, instr_valid;
  logic [15:0] jump_addr = '0, instr, instr_pc;
  int checks = 0, errors = 0, delivered = 0;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .halt(halt), .jump_en(jump_en), .jump_addr(jump_addr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  always @(posedge clk) rom_data <= rom(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the word on the output is always the next undelivered address of the
  // current stream; an unaccepted word is held; two quiet edges guarantee a word.
  initial begin
    logic [15:0] exp_pc, hold_instr, hold_pc;
    logic hold_pending;
    int quiet;
    exp_pc = '0; hold_pending = 1'b0; quiet = 0; hold_instr = '0; hold_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", rom_addr, 0);
        exp_pc = '0; hold_pending = 1'b0; quiet = 0;
      end else begin
        if (quiet >= 2) chk("sustain", instr_valid, 1);
        if (hold_pending) begin
          chk("hold_valid", instr_valid, 1);
          chk("hold_instr", instr, hold_instr);
          chk("hold_pc", instr_pc, hold_pc);
        end
        if (instr_valid) begin
          chk("order", instr_pc, exp_pc);
          chk("data", instr, rom(instr_pc));
        end
        hold_pending = instr_valid && !instr_ready && !jump_en;
        hold_instr = instr;
        hold_pc = instr_pc;
        if (instr_valid && instr_ready) begin
          exp_pc = exp_pc + 16'd1;
          delivered++;
        end
        if (jump_en) exp_pc = jump_addr;
        quiet = (jump_en || halt) ? 0 : (quiet < 2 ? quiet + 1 : 2);
      end
    end
  end

  initial begin
    logic [15:0] wrap_seq [4];
    wrap_seq[0] = 16'hFFFE; wrap_seq[1] = 16'hFFFF; wrap_seq[2] = 16'h0000; wrap_seq[3] = 16'h0001;
    step(); step();
    rst_n = 1'b1;
    chk("reset_addr", rom_addr, 16'h0000);
    chk("reset_valid", instr_valid, 0);
    step();
    chk("lat_edge1", instr_valid, 0);
    step();
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 16'h0000);
    chk("first_instr", instr, 16'h1000);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("stream_pc", instr_pc, i);
    end
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", instr_pc, 16'd4);
      chk("stall_addr", rom_addr, 16'd6);
    end
    instr_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      step();
      chk("resume_pc", instr_pc, i);
      chk("resume_valid", instr_valid, 1);
    end
    instr_ready = 1'b0;
    jump_en = 1'b1;
    jump_addr = 16'h0100;
    step();
    jump_en = 1'b0;
    instr_ready = 1'b1;
    chk("jump_flush", instr_valid, 0);
    chk("jump_addr", rom_addr, 16'h0100);
    step();
    chk("jump_gap", instr_valid, 0);
    step();
    chk("jump_pc", instr_pc, 16'h0100);
    chk("jump_instr", instr, 16'h1100);
    jump_en = 1'b1;
    jump_addr = 16'hFFFE;
    step();
    jump_en = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_pc", instr_pc, wrap_seq[i]);
      chk("wrap_valid", instr_valid, 1);
    end
    for (int i = 0; i < 7; i++) step();
    chk("halt_start_addr", rom_addr, 16'd10);
    halt = 1'b1;
    step();
    chk("drain_pc", instr_pc, 16'd9);
    chk("drain_valid", instr_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_idle", instr_valid, 0);
      chk("halt_addr", rom_addr, 16'd10);
    end
    halt = 1'b0;
    step();
    chk("unhalt_gap", instr_valid, 0);
    step();
    chk("unhalt_pc", instr_pc, 16'd10);
    chk("unhalt_valid", instr_valid, 1);
    for (int c = 0; c < 1000; c++) begin
      if (c == 500) begin
        instr_ready = 1'b0;
        jump_en = 1'b0;
        halt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_addr", rom_addr, 16'h0000);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
      instr_ready = $urandom_range(1, 0) == 1;
      jump_en = $urandom_range(39, 0) == 0;
      jump_addr = 16'($urandom);
      halt = $urandom_range(15, 0) == 0;
    end
    jump_en = 1'b0;
    halt = 1'b0;
    step();
    checks++;
    if (delivered < 300) begin
      errors++;
      $display("FAIL progress actual=%0d expected>=300", delivered);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
